// File: rtl/arp_table.sv
// arp_table -- ARP resolution table between the RX ARP parser and the TX builders.
//
// Learns IP->MAC bindings from ARP frames whose FCS checked good, asks the ARP
// TX builder for a reply when a request targets local_ip, and serves a
// one-cycle registered lookup port to the IP/UDP TX path.
//
// Optional feature macro: ARP_TABLE_AGING_EN
//   defined   -> per-entry age counter, reloaded on write, decremented on
//                age_tick, entry dropped when it reaches zero
//   undefined -> no counters, age_tick ignored
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   local_mac, local_ip    station addresses, static after reset
//   arp_data_done, rx_*    parsed ARP fields, valid with the done pulse
//   crc_valid, crc_error   FCS verdict for the frame just parsed
//   arp_resp_start, resp_* reply trigger and requester addresses
//   lkp_req, lkp_ip        lookup strobe and address
//   lkp_done/hit/mac       registered lookup result (mac is 0 on a miss)
//   age_tick               aging pulse
//   entry_count            number of valid entries
module arp_table #(
  parameter int DEPTH       = 4,
  parameter int AGE_MAX     = 300,
  parameter int FCS_TIMEOUT = 64
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [47:0]                local_mac,
  input  logic [31:0]                local_ip,
  input  logic                       arp_data_done,
  input  logic [15:0]                rx_opcode,
  input  logic [47:0]                rx_sha,
  input  logic [31:0]                rx_spa,
  input  logic [31:0]                rx_tpa,
  input  logic                       crc_valid,
  input  logic                       crc_error,
  output logic                       arp_resp_start,
  output logic [47:0]                resp_mac_d_addr,
  output logic [31:0]                resp_ip_d_addr,
  input  logic                       lkp_req,
  input  logic [31:0]                lkp_ip,
  output logic                       lkp_done,
  output logic                       lkp_hit,
  output logic [47:0]                lkp_mac,
  input  logic                       age_tick,
  output logic [$clog2(DEPTH+1)-1:0] entry_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(FCS_TIMEOUT + 1);
`ifdef ARP_TABLE_AGING_EN
  localparam int AW = $clog2(AGE_MAX + 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FCS, S_UPDATE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            isReq_q, isReq_d;
  logic [47:0]     sha_q, sha_d;
  logic [31:0]     spa_q, spa_d;
  logic [31:0]     tpa_q, tpa_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   victim_q, victim_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      ip_q  [DEPTH];
  logic [31:0]      ip_d  [DEPTH];
  logic [47:0]      mac_q [DEPTH];
  logic [47:0]      mac_d [DEPTH];
`ifdef ARP_TABLE_AGING_EN
  logic [AW-1:0]    age_q [DEPTH];
  logic [AW-1:0]    age_d [DEPTH];
`endif

  logic          opcodeOk, load, toLocal;
  logic          matchHit, freeHit, lkpHit_d;
  logic [IW-1:0] matchIdx, freeIdx, wrIdx;
  logic          wrEn, respStart_d;
  logic [47:0]   lkpMac_d;
  logic [CW-1:0] count_d;

  // local_mac is carried for the reply builder's benefit only; the table
  // itself never needs it.
  logic unused_inputs;
  assign unused_inputs = ^{local_mac, age_tick};

  assign opcodeOk = (rx_opcode == 16'd1) || (rx_opcode == 16'd2);
  assign toLocal  = (tpa_q == local_ip);

  // A new ARP is captured when idle, or while waiting for a verdict as long as
  // no verdict arrives in the same cycle (the verdict belongs to the old frame).
  assign load = arp_data_done && opcodeOk &&
                ((state_q == S_IDLE) ||
                 ((state_q == S_WAIT_FCS) && !crc_valid && !crc_error));

  assign isReq_d = load ? (rx_opcode == 16'd1) : isReq_q;
  assign sha_d   = load ? rx_sha : sha_q;
  assign spa_d   = load ? rx_spa : spa_q;
  assign tpa_d   = load ? rx_tpa : tpa_q;

  // Parallel compares against the current table. Scanning from the top down
  // lets the lowest matching / free index win.
  always_comb begin
    matchHit = 1'b0;
    matchIdx = '0;
    freeHit  = 1'b0;
    freeIdx  = '0;
    lkpHit_d = 1'b0;
    lkpMac_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == spa_q)) begin
        matchHit = 1'b1;
        matchIdx = IW'(i);
      end
      if (!valid_q[i]) begin
        freeHit = 1'b1;
        freeIdx = IW'(i);
      end
      if (valid_q[i] && (ip_q[i] == lkp_ip)) begin
        lkpHit_d = 1'b1;
        lkpMac_d = mac_q[i];
      end
    end
  end

  // Learn FSM: next state, timeout counter, write decision and reply trigger.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    victim_d    = victim_q;
    wrEn        = 1'b0;
    wrIdx       = '0;
    respStart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          timer_d = '0;
          state_d = S_WAIT_FCS;
        end
      end
      S_WAIT_FCS: begin
        if (crc_error) begin
          state_d = S_IDLE;
        end else if (crc_valid) begin
          state_d = S_UPDATE;
        end else if (load) begin
          timer_d = '0;
        end else if (timer_q == TW'(FCS_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_UPDATE: begin
        // A zero sender address is a probe and must never be learned.
        if (spa_q != '0) begin
          if (matchHit) begin
            wrEn  = 1'b1;
            wrIdx = matchIdx;
          end else if (toLocal) begin
            wrEn = 1'b1;
            if (freeHit) begin
              wrIdx = freeIdx;
            end else begin
              wrIdx    = victim_q;
              victim_d = (victim_q == IW'(DEPTH - 1)) ? '0 : victim_q + 1'b1;
            end
          end
        end
        if (isReq_q && toLocal) begin
          respStart_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Table next state. A write always wins over aging of the same entry, so a
  // write coinciding with age_tick leaves a full lifetime.
  always_comb begin
    valid_d = valid_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
`ifdef ARP_TABLE_AGING_EN
    age_d   = age_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (wrEn && (wrIdx == IW'(i))) begin
        valid_d[i] = 1'b1;
        ip_d[i]    = spa_q;
        mac_d[i]   = sha_q;
`ifdef ARP_TABLE_AGING_EN
        age_d[i]   = AW'(AGE_MAX);
      end else if (age_tick && valid_q[i] && (age_q[i] != '0)) begin
        age_d[i] = age_q[i] - 1'b1;
        if (age_q[i] == AW'(1)) begin
          valid_d[i] = 1'b0;
        end
`endif
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q         <= S_IDLE;
      isReq_q         <= 1'b0;
      sha_q           <= '0;
      spa_q           <= '0;
      tpa_q           <= '0;
      timer_q         <= '0;
      victim_q        <= '0;
      valid_q         <= '0;
      arp_resp_start  <= 1'b0;
      resp_mac_d_addr <= '0;
      resp_ip_d_addr  <= '0;
      lkp_done        <= 1'b0;
      lkp_hit         <= 1'b0;
      lkp_mac         <= '0;
      entry_count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
`ifdef ARP_TABLE_AGING_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      state_q        <= state_d;
      isReq_q        <= isReq_d;
      sha_q          <= sha_d;
      spa_q          <= spa_d;
      tpa_q          <= tpa_d;
      timer_q        <= timer_d;
      victim_q       <= victim_d;
      valid_q        <= valid_d;
      ip_q           <= ip_d;
      mac_q          <= mac_d;
`ifdef ARP_TABLE_AGING_EN
      age_q          <= age_d;
`endif
      entry_count    <= count_d;
      arp_resp_start <= respStart_d;
      if (respStart_d) begin
        resp_mac_d_addr <= sha_q;
        resp_ip_d_addr  <= spa_q;
      end
      lkp_done <= lkp_req;
      if (lkp_req) begin
        lkp_hit <= lkpHit_d;
        lkp_mac <= lkpMac_d;
      end
    end
  end

endmodule

// File: tb/tb_arp_table.sv
`timescale 1ns/1ps
module tb_arp_table;

   localparam int DEPTH       = 4;
   localparam int AGE_MAX     = 3;
   localparam int FCS_TIMEOUT = 64;
   localparam logic [31:0] LOCAL_IP  = 32'hC0A8_010A;
   localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_000A;
   localparam logic [31:0] IP_120    = 32'hC0A8_0178;
   localparam logic [31:0] OTHER_IP  = 32'hC0A8_0163;
   localparam logic [47:0] MAC_A     = 48'h84A0_DAB8_3142;
   localparam logic [47:0] MAC_B     = 48'h0011_2233_4455;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        arp_data_done = 1'b0;
   logic [15:0] rx_opcode = '0;
   logic [47:0] rx_sha = '0;
   logic [31:0] rx_spa = '0;
   logic [31:0] rx_tpa = '0;
   logic        crc_valid = 1'b0;
   logic        crc_error = 1'b0;
   logic        lkp_req = 1'b0;
   logic [31:0] lkp_ip = '0;
   logic        age_tick = 1'b0;
   logic        arp_resp_start, lkp_done, lkp_hit;
   logic [47:0] resp_mac_d_addr, lkp_mac;
   logic [31:0] resp_ip_d_addr;
   logic [2:0]  entry_count;

   int nCompared = 0;
   int nMismatched = 0;
   bit checkOn = 1'b0;
   bit randOn = 1'b0;

   arp_table #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX), .FCS_TIMEOUT(FCS_TIMEOUT)) dut (
      .aclk(aclk), .aresetn(aresetn), .local_mac(LOCAL_MAC), .local_ip(LOCAL_IP),
      .arp_data_done(arp_data_done), .rx_opcode(rx_opcode), .rx_sha(rx_sha),
      .rx_spa(rx_spa), .rx_tpa(rx_tpa), .crc_valid(crc_valid), .crc_error(crc_error),
      .arp_resp_start(arp_resp_start), .resp_mac_d_addr(resp_mac_d_addr),
      .resp_ip_d_addr(resp_ip_d_addr), .lkp_req(lkp_req), .lkp_ip(lkp_ip),
      .lkp_done(lkp_done), .lkp_hit(lkp_hit), .lkp_mac(lkp_mac),
      .age_tick(age_tick), .entry_count(entry_count));

   always #5 aclk = ~aclk;

   // Reference model: table as plain arrays, pending frame, scheduled update.
   bit          mValid [DEPTH];
   logic [31:0] mIp    [DEPTH];
   logic [47:0] mMac   [DEPTH];
   int          mAge   [DEPTH];
   int          mVictim;
   bit          pValid, pReq, uPend, uReq, respCycle;
   logic [47:0] pSha, uSha;
   logic [31:0] pSpa, pTpa, uSpa, uTpa;
   int          pWait;
   bit          eResp, eDone, eHit;
   logic [47:0] eRespMac, eMac;
   logic [31:0] eRespIp;
   int          eCount;

   // The model advances on every clock edge using the inputs that edge sees.
   always @(posedge aclk) begin
      int  idx;
      int  wIdx;
      bit  busy;
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mValid[i] = 1'b0; mIp[i] = '0; mMac[i] = '0; mAge[i] = 0;
         end
         mVictim = 0; pValid = 1'b0; uPend = 1'b0; respCycle = 1'b0; pWait = 0;
         eResp = 1'b0; eRespMac = '0; eRespIp = '0;
         eDone = 1'b0; eHit = 1'b0; eMac = '0; eCount = 0;
      end else begin
         eDone = lkp_req;
         if (lkp_req) begin
            eHit = 1'b0; eMac = '0;
            for (int i = DEPTH - 1; i >= 0; i--)
               if (mValid[i] && mIp[i] == lkp_ip) begin eHit = 1'b1; eMac = mMac[i]; end
         end
         busy = uPend || respCycle;
         respCycle = 1'b0; eResp = 1'b0; wIdx = -1;
         if (uPend) begin
            uPend = 1'b0;
            if (uSpa != 32'h0) begin
               idx = -1;
               for (int i = 0; i < DEPTH; i++)
                  if (idx < 0 && mValid[i] && mIp[i] == uSpa) idx = i;
               if (idx < 0 && uTpa == LOCAL_IP) begin
                  for (int i = 0; i < DEPTH; i++)
                     if (idx < 0 && !mValid[i]) idx = i;
                  if (idx < 0) begin
                     idx = mVictim;
                     mVictim = (mVictim + 1) % DEPTH;
                  end
               end
               if (idx >= 0) begin
                  mValid[idx] = 1'b1; mIp[idx] = uSpa; mMac[idx] = uSha; mAge[idx] = AGE_MAX;
                  wIdx = idx;
               end
            end
            if (uReq && uTpa == LOCAL_IP) begin
               eResp = 1'b1; eRespMac = uSha; eRespIp = uSpa; respCycle = 1'b1;
            end
         end
`ifdef ARP_TABLE_AGING_EN
         if (age_tick)
            for (int i = 0; i < DEPTH; i++)
               if (i != wIdx && mValid[i]) begin
                  mAge[i] = mAge[i] - 1;
                  if (mAge[i] == 0) mValid[i] = 1'b0;
               end
`endif
         if (!busy) begin
            if (pValid) begin
               if (crc_error) pValid = 1'b0;
               else if (crc_valid) begin
                  uPend = 1'b1; uReq = pReq; uSha = pSha; uSpa = pSpa; uTpa = pTpa;
                  pValid = 1'b0;
               end else if (arp_data_done && (rx_opcode == 16'd1 || rx_opcode == 16'd2)) begin
                  pReq = (rx_opcode == 16'd1); pSha = rx_sha; pSpa = rx_spa; pTpa = rx_tpa;
                  pWait = 0;
               end else begin
                  pWait = pWait + 1;
                  if (pWait >= FCS_TIMEOUT) pValid = 1'b0;
               end
            end else if (arp_data_done && (rx_opcode == 16'd1 || rx_opcode == 16'd2)) begin
               pValid = 1'b1; pWait = 0;
               pReq = (rx_opcode == 16'd1); pSha = rx_sha; pSpa = rx_spa; pTpa = rx_tpa;
            end
         end
         eCount = 0;
         for (int i = 0; i < DEPTH; i++) eCount = eCount + int'(mValid[i]);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared = nCompared + 1;
      if (act !== exp) begin
         nMismatched = nMismatched + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle, once reset has been applied, the outputs must follow the model.
   initial forever begin
      @(negedge aclk);
      if (checkOn) begin
         checkOutput("m_resp_start", 64'(arp_resp_start), 64'(eResp));
         checkOutput("m_resp_mac", 64'(resp_mac_d_addr), 64'(eRespMac));
         checkOutput("m_resp_ip", 64'(resp_ip_d_addr), 64'(eRespIp));
         checkOutput("m_lkp_done", 64'(lkp_done), 64'(eDone));
         if (eDone) begin
            checkOutput("m_lkp_hit", 64'(lkp_hit), 64'(eHit));
            checkOutput("m_lkp_mac", 64'(lkp_mac), 64'(eMac));
         end
         checkOutput("m_count", 64'(entry_count), 64'(eCount));
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] op, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [31:0] tpa);
      arp_data_done = 1'b1; rx_opcode = op; rx_sha = sha; rx_spa = spa; rx_tpa = tpa;
      tick();
      arp_data_done = 1'b0;
   endtask

   task automatic pulseValid();
      crc_valid = 1'b1;
      tick();
      crc_valid = 1'b0;
   endtask

   task automatic learnIp(input logic [15:0] op, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa);
      applyStimulus(op, sha, spa, tpa);
      pulseValid();
      tick();
      tick();
   endtask

   task automatic doLookup(input logic [31:0] ip);
      lkp_req = 1'b1; lkp_ip = ip;
      tick();
      lkp_req = 1'b0;
   endtask

   task automatic doReset();
      aresetn = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic ageTick();
      age_tick = 1'b1;
      tick();
      age_tick = 1'b0;
      tick();
   endtask

   // Background random lookups (and aging pulses) during the random phase.
   initial forever begin
      @(posedge aclk);
      #1;
      if (randOn) begin
         lkp_req = 1'($urandom_range(0, 1));
         lkp_ip  = {24'hC0A801, 8'($urandom_range(0, 8))};
`ifdef ARP_TABLE_AGING_EN
         age_tick = ($urandom_range(0, 9) == 0);
`endif
      end
   end

   initial begin
      $display("[TB] arp_table bench start");
      tick();
      checkOn = 1'b1;
      tick();
      checkOutput("rst_resp_start", 64'(arp_resp_start), 64'd0);
      checkOutput("rst_lkp_done", 64'(lkp_done), 64'd0);
      checkOutput("rst_lkp_mac", 64'(lkp_mac), 64'd0);
      checkOutput("rst_count", 64'(entry_count), 64'd0);
      aresetn = 1'b1;

      // Request aimed at us: learn + reply two cycles after crc_valid.
      applyStimulus(16'd1, MAC_A, IP_120, LOCAL_IP);
      pulseValid();
      checkOutput("resp_not_M1", 64'(arp_resp_start), 64'd0);
      tick();
      checkOutput("resp_start_M2", 64'(arp_resp_start), 64'd1);
      checkOutput("resp_mac_M2", 64'(resp_mac_d_addr), 64'(MAC_A));
      checkOutput("resp_ip_M2", 64'(resp_ip_d_addr), 64'(IP_120));
      doLookup(IP_120);
      checkOutput("resp_end_M3", 64'(arp_resp_start), 64'd0);
      checkOutput("lkp1_hit", 64'(lkp_hit), 64'd1);
      checkOutput("lkp1_mac", 64'(lkp_mac), 64'(MAC_A));
      checkOutput("lkp1_count", 64'(entry_count), 64'd1);

      // Bad FCS, then no verdict at all: nothing learned.
      doReset();
      applyStimulus(16'd1, MAC_A, IP_120, LOCAL_IP);
      crc_error = 1'b1; tick(); crc_error = 1'b0;
      repeat (3) tick();
      doLookup(IP_120);
      checkOutput("crcerr_hit", 64'(lkp_hit), 64'd0);
      checkOutput("crcerr_count", 64'(entry_count), 64'd0);
      applyStimulus(16'd1, MAC_A, IP_120, LOCAL_IP);
      repeat (FCS_TIMEOUT + 6) tick();
      pulseValid();
      repeat (3) tick();
      doLookup(IP_120);
      checkOutput("timeout_hit", 64'(lkp_hit), 64'd0);
      checkOutput("timeout_count", 64'(entry_count), 64'd0);

      // Replies: unknown sender not for us is ignored; a known one is refreshed.
      learnIp(16'd2, MAC_A, IP_120, OTHER_IP);
      doLookup(IP_120);
      checkOutput("reply_noins_hit", 64'(lkp_hit), 64'd0);
      learnIp(16'd1, MAC_A, IP_120, LOCAL_IP);
      applyStimulus(16'd2, MAC_B, IP_120, OTHER_IP);
      pulseValid();
      tick();
      checkOutput("reply_no_resp", 64'(arp_resp_start), 64'd0);
      doLookup(IP_120);
      checkOutput("reply_upd_mac", 64'(lkp_mac), 64'(MAC_B));
      checkOutput("reply_upd_count", 64'(entry_count), 64'd1);

      // Fill past capacity: round-robin eviction starting at entry 0.
      doReset();
      for (int k = 1; k <= 5; k++)
         learnIp(16'd2, {40'h0A0B0C0D0E, 8'(k)}, {24'hC0A801, 8'(k)}, LOCAL_IP);
      doLookup(32'hC0A8_0101);
      checkOutput("evict_ip1_hit", 64'(lkp_hit), 64'd0);
      doLookup(32'hC0A8_0105);
      checkOutput("evict_ip5_mac", 64'(lkp_mac), 64'h0A0B0C0D0E05);
      checkOutput("evict_count", 64'(entry_count), 64'd4);
      learnIp(16'd2, 48'h0A0B0C0D0E06, 32'hC0A8_0106, LOCAL_IP);
      doLookup(32'hC0A8_0102);
      checkOutput("evict_ip2_hit", 64'(lkp_hit), 64'd0);
      doLookup(32'hC0A8_0103);
      checkOutput("evict_ip3_hit", 64'(lkp_hit), 64'd1);

      // Reset while waiting for the verdict aborts the reply and clears the table.
      applyStimulus(16'd1, MAC_A, IP_120, LOCAL_IP);
      tick();
      aresetn = 1'b0; tick(); aresetn = 1'b1;
      pulseValid();
      tick();
      checkOutput("rstwait_resp", 64'(arp_resp_start), 64'd0);
      doLookup(IP_120);
      checkOutput("rstwait_hit", 64'(lkp_hit), 64'd0);
      checkOutput("rstwait_count", 64'(entry_count), 64'd0);

`ifdef ARP_TABLE_AGING_EN
      learnIp(16'd1, MAC_A, IP_120, LOCAL_IP);
      repeat (3) ageTick();
      doLookup(IP_120);
      checkOutput("age_expired", 64'(lkp_hit), 64'd0);
      learnIp(16'd1, MAC_A, IP_120, LOCAL_IP);
      repeat (2) ageTick();
      learnIp(16'd2, MAC_B, IP_120, OTHER_IP);
      repeat (2) ageTick();
      doLookup(IP_120);
      checkOutput("age_refresh_mac", 64'(lkp_mac), 64'(MAC_B));
      ageTick();
      doLookup(IP_120);
      checkOutput("age_refresh_end", 64'(lkp_hit), 64'd0);
`endif

      // Random phase against the model.
      doReset();
      randOn = 1'b1;
      for (int it = 0; it < 250; it++) begin
         int          r;
         logic [15:0] op;
         logic [31:0] spa, tpa;
         r   = $urandom_range(0, 9);
         op  = (r < 4) ? 16'd1 : (r < 8) ? 16'd2 : (r == 8) ? 16'd3 : 16'd0;
         spa = ($urandom_range(0, 19) == 0) ? 32'h0 : {24'hC0A801, 8'($urandom_range(1, 7))};
         tpa = ($urandom_range(0, 9) < 6) ? LOCAL_IP : {24'hC0A801, 8'($urandom_range(20, 30))};
         applyStimulus(op, {16'($urandom), $urandom}, spa, tpa);
         repeat ($urandom_range(0, 4)) tick();
         if ($urandom_range(0, 9) == 0)
            applyStimulus(16'd1, {16'($urandom), $urandom}, spa, LOCAL_IP);
         r = $urandom_range(0, 99);
         if (r < 70) pulseValid();
         else if (r < 90) begin crc_error = 1'b1; tick(); crc_error = 1'b0; end
         else if (r < 95) begin crc_valid = 1'b1; crc_error = 1'b1; tick(); crc_valid = 1'b0; crc_error = 1'b0; end
         else repeat (FCS_TIMEOUT + 4) tick();
         repeat (3) tick();
      end
      randOn = 1'b0;
      repeat (3) tick();
      lkp_req = 1'b0;
      age_tick = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
